// File: rtl/reorder_buffer_pkg.sv
// Purpose: shared ROB sizing constants, entry layout and the tag wrap helper.
// Latency: n/a (types and a combinational function only).
// Backpressure: n/a.
package reorder_buffer_pkg;

   localparam int ROB_SIZE  = 16;
   localparam int ROB_WIDTH = 4;

   typedef logic [ROB_WIDTH-1:0] rob_tag_t;

   // Tag 0 means "no tag", so the usable tags are 1..ROB_SIZE-1.
   localparam rob_tag_t ZERO_ROB = '0;
   localparam rob_tag_t MAX_TAG  = rob_tag_t'(ROB_SIZE - 1);

   typedef struct packed {
      logic        busy;
      logic        ready;
      logic [4:0]  rd;
      logic [31:0] value;
      logic        mispredict;
      logic [31:0] target_pc;
   } rob_entry_t;

   // Next tag in circular order; wraps from MAX_TAG to 1 and never yields 0.
   function automatic rob_tag_t rob_tag_inc(input rob_tag_t t);
      return (t == MAX_TAG) ? rob_tag_t'(1) : t + rob_tag_t'(1);
   endfunction

endpackage

// File: rtl/reorder_buffer.sv
// Purpose: in-order reorder buffer; allocates tags, captures CDB results, retires the head, flushes on mispredict.
// Latency: allocate at edge N, CDB write at N+1, commit outputs visible during N+2 (combinational from head).
// Backpressure: full stalls the decoder; an alloc while full or during a flush is dropped silently.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   alloc_valid/alloc_rd         issue one instruction; alloc_tag is the tag it receives; full blocks it
//   cdb_valid/tag/value/mispredict/target_pc   result broadcast
//   q1_tag/q2_tag -> qN_ready/qN_value         operand lookup with same-cycle CDB bypass
//   commit_reg/commit_tag/commit_value         retire port to the register file
//   flush/flush_pc               restart request when a mispredicted branch retires
module reorder_buffer
   import reorder_buffer_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        alloc_valid,
   input  logic [4:0]  alloc_rd,
   output logic [3:0]  alloc_tag,
   output logic        full,
   input  logic        cdb_valid,
   input  logic [3:0]  cdb_tag,
   input  logic [31:0] cdb_value,
   input  logic        cdb_mispredict,
   input  logic [31:0] cdb_target_pc,
   input  logic [3:0]  q1_tag,
   input  logic [3:0]  q2_tag,
   output logic        q1_ready,
   output logic        q2_ready,
   output logic [31:0] q1_value,
   output logic [31:0] q2_value,
   output logic [4:0]  commit_reg,
   output logic [3:0]  commit_tag,
   output logic [31:0] commit_value,
   output logic        flush,
   output logic [31:0] flush_pc
);

   rob_entry_t entries [ROB_SIZE];
   rob_tag_t   head;
   rob_tag_t   tail;
   rob_tag_t   count;

   rob_entry_t head_e;
   logic       commit_fire;
   logic       alloc_fire;
   logic       wb_fire;

   // Ready/value for an operand tag: stored result first, then the live CDB broadcast.
   function automatic logic [32:0] operand(input rob_tag_t q, input rob_entry_t e,
                                           input logic bv, input rob_tag_t bt,
                                           input logic [31:0] bval);
      if (q == ZERO_ROB)      return '0;
      if (e.ready)            return {1'b1, e.value};
      if (bv && (bt == q))    return {1'b1, bval};
      return '0;
   endfunction

   assign head_e      = entries[head];
   assign full        = (count == MAX_TAG);
   assign alloc_tag   = tail;

   // head_e.ready only counts when something is in flight; a CDB write to the head
   // lands at the edge, so the commit it enables is always a cycle later.
   assign commit_fire  = (count != ZERO_ROB) && head_e.ready;
   assign commit_reg   = commit_fire ? head_e.rd    : '0;
   assign commit_tag   = commit_fire ? head          : '0;
   assign commit_value = commit_fire ? head_e.value : '0;
   assign flush        = commit_fire && head_e.mispredict;
   assign flush_pc     = flush ? head_e.target_pc : '0;

   // full uses the pre-edge count, so a same-cycle commit never frees a slot for this alloc.
   assign alloc_fire = alloc_valid && !full && !flush;
   assign wb_fire    = cdb_valid && (cdb_tag != ZERO_ROB) && entries[cdb_tag].busy;

   assign {q1_ready, q1_value} = operand(q1_tag, entries[q1_tag], cdb_valid, cdb_tag, cdb_value);
   assign {q2_ready, q2_value} = operand(q2_tag, entries[q2_tag], cdb_valid, cdb_tag, cdb_value);

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         // The retiring branch's rd write is already on the commit port this cycle.
         for (int i = 0; i < ROB_SIZE; i++) begin
            entries[i] <= '0;
         end
         head  <= rob_tag_t'(1);
         tail  <= rob_tag_t'(1);
         count <= '0;
      end else begin
         if (wb_fire) begin
            entries[cdb_tag].ready      <= 1'b1;
            entries[cdb_tag].value      <= cdb_value;
            entries[cdb_tag].mispredict <= cdb_mispredict;
            entries[cdb_tag].target_pc  <= cdb_target_pc;
         end
         // Head and tail only coincide when empty (no commit) or full (no alloc).
         if (commit_fire) begin
            entries[head] <= '0;
         end
         if (alloc_fire) begin
            entries[tail].busy       <= 1'b1;
            entries[tail].ready      <= 1'b0;
            entries[tail].rd         <= alloc_rd;
            entries[tail].mispredict <= 1'b0;
         end
         if (commit_fire) head <= rob_tag_inc(head);
         if (alloc_fire)  tail <= rob_tag_inc(tail);
         case ({alloc_fire, commit_fire})
            2'b10:   count <= count + rob_tag_t'(1);
            2'b01:   count <= count - rob_tag_t'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// Purpose: self-checking bench for reorder_buffer (vector table, directed corner cases, random vs queue model).
// Latency: outputs sampled on the falling edge, model advanced for the following rising edge.
// Backpressure: model drops allocs when 15 entries are in flight or a flush retires.
module tb_reorder_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        alloc_valid;
   logic [4:0]  alloc_rd;
   logic [3:0]  alloc_tag;
   logic        full;
   logic        cdb_valid;
   logic [3:0]  cdb_tag;
   logic [31:0] cdb_value;
   logic        cdb_mispredict;
   logic [31:0] cdb_target_pc;
   logic [3:0]  q1_tag, q2_tag;
   logic        q1_ready, q2_ready;
   logic [31:0] q1_value, q2_value;
   logic [4:0]  commit_reg;
   logic [3:0]  commit_tag;
   logic [31:0] commit_value;
   logic        flush;
   logic [31:0] flush_pc;

   reorder_buffer dut (
      .clk(clk), .rst(rst),
      .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_tag(alloc_tag), .full(full),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .cdb_mispredict(cdb_mispredict), .cdb_target_pc(cdb_target_pc),
      .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_ready(q1_ready), .q2_ready(q2_ready),
      .q1_value(q1_value), .q2_value(q2_value),
      .commit_reg(commit_reg), .commit_tag(commit_tag), .commit_value(commit_value),
      .flush(flush), .flush_pc(flush_pc)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: program-ordered queue of in-flight instructions.
   typedef struct {
      logic [3:0]  tag;
      logic [4:0]  rd;
      bit          rdy;
      logic [31:0] val;
      bit          mis;
      logic [31:0] tpc;
   } ment_t;
   ment_t mq[$];
   int    m_tail = 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int find(input logic [3:0] t);
      foreach (mq[i]) if (mq[i].tag == t) return i;
      return -1;
   endfunction

   function automatic logic [32:0] m_operand(input logic [3:0] t);
      int k;
      if (t == 4'd0) return '0;
      k = find(t);
      if (k >= 0) if (mq[k].rdy) return {1'b1, mq[k].val};
      if (cdb_valid && cdb_tag == t) return {1'b1, cdb_value};
      return '0;
   endfunction

   task automatic check_model();
      logic [4:0]  er;
      logic [3:0]  et;
      logic [31:0] ev, efp;
      bit          ef;
      logic [32:0] o1, o2;
      er = '0; et = '0; ev = '0; ef = 1'b0; efp = '0;
      if (mq.size() > 0) begin
         if (mq[0].rdy) begin
            er = mq[0].rd; et = mq[0].tag; ev = mq[0].val; ef = mq[0].mis;
            if (ef) efp = mq[0].tpc;
         end
      end
      o1 = m_operand(q1_tag);
      o2 = m_operand(q2_tag);
      chk("m_full",         32'(full),         32'(mq.size() == 15));
      chk("m_alloc_tag",    32'(alloc_tag),    32'(m_tail));
      chk("m_commit_reg",   32'(commit_reg),   32'(er));
      chk("m_commit_tag",   32'(commit_tag),   32'(et));
      chk("m_commit_value", commit_value,      ev);
      chk("m_flush",        32'(flush),        32'(ef));
      chk("m_flush_pc",     flush_pc,          efp);
      chk("m_q1_ready",     32'(q1_ready),     32'(o1[32]));
      chk("m_q1_value",     q1_value,          o1[31:0]);
      chk("m_q2_ready",     32'(q2_ready),     32'(o2[32]));
      chk("m_q2_value",     q2_value,          o2[31:0]);
   endtask

   // Advance the model across the coming rising edge using the current inputs.
   task automatic update_model();
      bit    c, fl, was_full;
      int    k;
      ment_t e;
      c        = (mq.size() > 0) && mq[0].rdy;
      fl       = c && mq[0].mis;
      was_full = (mq.size() == 15);
      if (rst || fl) begin
         mq.delete();
         m_tail = 1;
         return;
      end
      if (cdb_valid && cdb_tag != 4'd0) begin
         k = find(cdb_tag);
         if (k >= 0) begin
            e = mq[k];
            e.rdy = 1'b1; e.val = cdb_value; e.mis = cdb_mispredict; e.tpc = cdb_target_pc;
            mq[k] = e;
         end
      end
      if (c) void'(mq.pop_front());
      if (alloc_valid && !was_full) begin
         e.tag = 4'(m_tail); e.rd = alloc_rd; e.rdy = 1'b0; e.val = '0; e.mis = 1'b0; e.tpc = '0;
         mq.push_back(e);
         m_tail = (m_tail == 15) ? 1 : m_tail + 1;
      end
   endtask

   task automatic finish_cycle();
      check_model();
      update_model();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc();
      @(negedge clk);
      finish_cycle();
   endtask

   task automatic idle();
      rst = 1'b0; alloc_valid = 1'b0; alloc_rd = '0;
      cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0; cdb_mispredict = 1'b0; cdb_target_pc = '0;
      q1_tag = '0; q2_tag = '0;
   endtask

   typedef struct {
      bit          av;  logic [4:0]  rd;
      bit          cv;  logic [3:0]  ct;  logic [31:0] cval; bit cm; logic [31:0] ctpc;
      logic [3:0]  q1;  logic [3:0]  q2;
      logic [3:0]  e_atag;
      logic [4:0]  e_creg; logic [3:0] e_ctag; logic [31:0] e_cval;
      bit          e_fl;   logic [31:0] e_fpc;
      bit          e_q1r;  logic [31:0] e_q1v; bit e_q2r;
   } vec_t;

   function automatic vec_t v(input bit av, input logic [4:0] rd,
                              input bit cv, input logic [3:0] ct, input logic [31:0] cval,
                              input bit cm, input logic [31:0] ctpc,
                              input logic [3:0] q1, input logic [3:0] q2,
                              input logic [3:0] e_atag, input logic [4:0] e_creg,
                              input logic [3:0] e_ctag, input logic [31:0] e_cval,
                              input bit e_fl, input logic [31:0] e_fpc,
                              input bit e_q1r, input logic [31:0] e_q1v, input bit e_q2r);
      vec_t r;
      r.av = av; r.rd = rd; r.cv = cv; r.ct = ct; r.cval = cval; r.cm = cm; r.ctpc = ctpc;
      r.q1 = q1; r.q2 = q2; r.e_atag = e_atag; r.e_creg = e_creg; r.e_ctag = e_ctag;
      r.e_cval = e_cval; r.e_fl = e_fl; r.e_fpc = e_fpc; r.e_q1r = e_q1r; r.e_q1v = e_q1v;
      r.e_q2r = e_q2r;
      return r;
   endfunction

   vec_t tbl[18];

   initial begin
      idle();
      rst = 1'b1;

      // In-order retire (0-6), mispredict flush (7-12), operand bypass (13-17).
      //           av rd cv ct cval    cm ctpc    q1 q2 | atag creg ctag cval    fl fpc     q1r q1v     q2r
      tbl[0]  = v(1, 5, 0, 0, 0,      0, 0,      0, 0,   1,   0,   0,   0,      0, 0,      0,  0,      0);
      tbl[1]  = v(1, 6, 0, 0, 0,      0, 0,      0, 0,   2,   0,   0,   0,      0, 0,      0,  0,      0);
      tbl[2]  = v(0, 0, 1, 2, 'h22,   0, 0,      2, 0,   3,   0,   0,   0,      0, 0,      1,  'h22,   0);
      tbl[3]  = v(0, 0, 1, 1, 'h11,   0, 0,      2, 0,   3,   0,   0,   0,      0, 0,      1,  'h22,   0);
      tbl[4]  = v(0, 0, 0, 0, 0,      0, 0,      0, 0,   3,   5,   1,   'h11,   0, 0,      0,  0,      0);
      tbl[5]  = v(0, 0, 0, 0, 0,      0, 0,      0, 0,   3,   6,   2,   'h22,   0, 0,      0,  0,      0);
      tbl[6]  = v(0, 0, 0, 0, 0,      0, 0,      0, 0,   3,   0,   0,   0,      0, 0,      0,  0,      0);
      tbl[7]  = v(1, 1, 0, 0, 0,      0, 0,      0, 0,   3,   0,   0,   0,      0, 0,      0,  0,      0);
      tbl[8]  = v(1, 7, 0, 0, 0,      0, 0,      0, 0,   4,   0,   0,   0,      0, 0,      0,  0,      0);
      tbl[9]  = v(0, 0, 1, 3, 'h104,  1, 'h100,  0, 0,   5,   0,   0,   0,      0, 0,      0,  0,      0);
      tbl[10] = v(1, 9, 1, 4, 'h77,   0, 0,      0, 0,   5,   1,   3,   'h104,  1, 'h100,  0,  0,      0);
      tbl[11] = v(0, 0, 0, 0, 0,      0, 0,      0, 0,   1,   0,   0,   0,      0, 0,      0,  0,      0);
      tbl[12] = v(0, 0, 0, 0, 0,      0, 0,      4, 0,   1,   0,   0,   0,      0, 0,      0,  0,      0);
      tbl[13] = v(1, 2, 0, 0, 0,      0, 0,      0, 0,   1,   0,   0,   0,      0, 0,      0,  0,      0);
      tbl[14] = v(1, 3, 0, 0, 0,      0, 0,      0, 0,   2,   0,   0,   0,      0, 0,      0,  0,      0);
      tbl[15] = v(1, 4, 0, 0, 0,      0, 0,      0, 0,   3,   0,   0,   0,      0, 0,      0,  0,      0);
      tbl[16] = v(0, 0, 1, 3, 'hABCD, 0, 0,      3, 0,   4,   0,   0,   0,      0, 0,      1,  'hABCD, 0);
      tbl[17] = v(0, 0, 0, 0, 0,      0, 0,      3, 1,   4,   0,   0,   0,      0, 0,      1,  'hABCD, 0);

      // Reset then idle.
      cyc();
      cyc();
      idle();
      @(negedge clk);
      chk("rst_alloc_tag",  32'(alloc_tag),  32'd1);
      chk("rst_full",       32'(full),       32'd0);
      chk("rst_commit_reg", 32'(commit_reg), 32'd0);
      chk("rst_flush",      32'(flush),      32'd0);
      chk("rst_flush_pc",   flush_pc,        32'd0);
      chk("rst_q1_ready",   32'(q1_ready),   32'd0);
      finish_cycle();

      for (int i = 0; i < 18; i++) begin
         alloc_valid = tbl[i].av; alloc_rd = tbl[i].rd;
         cdb_valid = tbl[i].cv; cdb_tag = tbl[i].ct; cdb_value = tbl[i].cval;
         cdb_mispredict = tbl[i].cm; cdb_target_pc = tbl[i].ctpc;
         q1_tag = tbl[i].q1; q2_tag = tbl[i].q2;
         @(negedge clk);
         chk($sformatf("v%0d_alloc_tag", i),    32'(alloc_tag),    32'(tbl[i].e_atag));
         chk($sformatf("v%0d_commit_reg", i),   32'(commit_reg),   32'(tbl[i].e_creg));
         chk($sformatf("v%0d_commit_tag", i),   32'(commit_tag),   32'(tbl[i].e_ctag));
         chk($sformatf("v%0d_commit_value", i), commit_value,      tbl[i].e_cval);
         chk($sformatf("v%0d_flush", i),        32'(flush),        32'(tbl[i].e_fl));
         chk($sformatf("v%0d_flush_pc", i),     flush_pc,          tbl[i].e_fpc);
         chk($sformatf("v%0d_q1_ready", i),     32'(q1_ready),     32'(tbl[i].e_q1r));
         chk($sformatf("v%0d_q1_value", i),     q1_value,          tbl[i].e_q1v);
         chk($sformatf("v%0d_q2_ready", i),     32'(q2_ready),     32'(tbl[i].e_q2r));
         finish_cycle();
      end

      // Full and wrap.
      idle(); rst = 1'b1; cyc(); idle();
      for (int i = 0; i < 15; i++) begin
         alloc_valid = 1'b1; alloc_rd = 5'(i + 1);
         cyc();
      end
      @(negedge clk);
      chk("full_at_15",     32'(full),      32'd1);
      chk("full_alloc_tag", 32'(alloc_tag), 32'd1);
      finish_cycle();                       // 16th alloc, ignored
      idle(); cdb_valid = 1'b1; cdb_tag = 4'd1; cdb_value = 32'h5a5a;
      cyc();
      idle(); alloc_valid = 1'b1; alloc_rd = 5'd20;
      @(negedge clk);
      chk("full_commit_tag", 32'(commit_tag), 32'd1);
      chk("full_still_full", 32'(full),       32'd1);
      finish_cycle();                       // commit frees a slot only after this edge
      idle();
      @(negedge clk);
      chk("full_freed",     32'(full),      32'd0);
      chk("wrap_alloc_tag", 32'(alloc_tag), 32'd1);
      finish_cycle();
      alloc_valid = 1'b1; alloc_rd = 5'd21;
      cyc();
      idle();
      @(negedge clk);
      chk("wrap_next_tag", 32'(alloc_tag), 32'd2);
      chk("wrap_refull",   32'(full),      32'd1);
      finish_cycle();

      // Simultaneous alloc and commit at count=4.
      idle(); rst = 1'b1; cyc(); idle();
      for (int i = 0; i < 4; i++) begin
         alloc_valid = 1'b1; alloc_rd = 5'(i + 10);
         cyc();
      end
      idle(); cdb_valid = 1'b1; cdb_tag = 4'd1; cdb_value = 32'h1234;
      cyc();
      idle(); alloc_valid = 1'b1; alloc_rd = 5'd9;
      @(negedge clk);
      chk("sim_commit_tag", 32'(commit_tag), 32'd1);
      chk("sim_alloc_tag",  32'(alloc_tag),  32'd5);
      finish_cycle();
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         chk("sim_not_full", 32'(full), 32'd0);
         finish_cycle();
      end
      idle();
      @(negedge clk);
      chk("sim_full_after_11", 32'(full),      32'd1);
      chk("sim_tail_wrapped",  32'(alloc_tag), 32'd2);
      finish_cycle();
      cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_value = 32'h2222;
      cyc();
      idle();
      @(negedge clk);
      chk("sim_head_advanced", 32'(commit_tag), 32'd2);
      finish_cycle();

      // Reset mid-operation overrides everything.
      rst = 1'b1; alloc_valid = 1'b1; cdb_valid = 1'b1; cdb_tag = 4'd3; cdb_value = 32'h3;
      cyc();
      idle();
      @(negedge clk);
      chk("mid_rst_alloc_tag",  32'(alloc_tag),  32'd1);
      chk("mid_rst_full",       32'(full),       32'd0);
      chk("mid_rst_commit_reg", 32'(commit_reg), 32'd0);
      finish_cycle();

      // Random traffic against the queue model.
      for (int n = 0; n < 3000; n++) begin
         rst            = ($urandom_range(0, 149) == 0);
         alloc_valid    = ($urandom_range(0, 2) != 0);
         alloc_rd       = 5'($urandom);
         cdb_valid      = $urandom_range(0, 1);
         if (mq.size() > 0 && $urandom_range(0, 3) != 0)
            cdb_tag = mq[$urandom_range(0, mq.size() - 1)].tag;
         else
            cdb_tag = 4'($urandom);
         cdb_value      = $urandom;
         cdb_mispredict = ($urandom_range(0, 19) == 0);
         cdb_target_pc  = $urandom;
         q1_tag         = 4'($urandom);
         q2_tag         = 4'($urandom);
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
